// File: rtl/sobel_out_pkg.sv
// Shared types and constants for the Sobel output write path.
package sobel_out_pkg;

  localparam int unsigned WORD_BITS      = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    StIdle,
    StAccept,
    StPad,
    StFlush,
    StDone
  } out_state_t;

  function automatic int unsigned words_per_row(input int unsigned width);
    return (width + WORD_BITS - 1) / WORD_BITS;
  endfunction

endpackage

// File: rtl/out_pixel_counter.sv
// Column/row position tracker for the output path; flags the last pixel of a row,
// a completed row and the end of the image.
module out_pixel_counter #(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_col_inc,
  input  logic i_row_adv,
  output logic o_col_last,
  output logic o_row_end,
  output logic o_img_end
);

  localparam int unsigned ColW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned RowW = $clog2(IMG_HEIGHT + 1);

  localparam logic [ColW-1:0] ColLast = ColW'(IMG_WIDTH - 1);
  localparam logic [ColW-1:0] ColEnd  = ColW'(IMG_WIDTH);
  localparam logic [RowW-1:0] RowLast = RowW'(IMG_HEIGHT - 1);

  logic [ColW-1:0] r_col_cnt;
  logic [RowW-1:0] r_row_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_col_cnt <= '0;
      r_row_cnt <= '0;
    end else if (i_row_adv) begin
      r_col_cnt <= '0;
      r_row_cnt <= r_row_cnt + RowW'(1);
    end else if (i_col_inc) begin
      r_col_cnt <= r_col_cnt + ColW'(1);
    end
  end

  assign o_col_last = (r_col_cnt == ColLast);
  assign o_row_end  = (r_col_cnt == ColEnd);
  assign o_img_end  = o_row_end && (r_row_cnt == RowLast);

endmodule

// File: rtl/output_write_ctrl.sv
// Sequencer that packs the serial edge-pixel stream into 32-bit outputBuffer words,
// zero-pads each row's last word and issues addressed word writes.
module output_write_ctrl
  import sobel_out_pkg::*;
#(
  parameter int unsigned IMG_WIDTH  = 320,
  parameter int unsigned IMG_HEIGHT = 240,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic        i_pix_valid,
  input  logic        i_pix_in,
  output logic        o_pix_ready,
  output logic        o_out_en,
  output logic        o_edge_pixel,
  input  logic        i_out_full,
  input  logic        i_mem_ready,
  output logic        o_write_out_enable,
  output logic [31:0] o_write_addr,
  output logic        o_img_done,
  output logic        o_busy
);

  localparam logic [4:0] BitLast = 5'(WORD_BITS - 1);

  out_state_t  r_state;
  logic [4:0]  r_bit_cnt;
  logic [31:0] r_addr;

  logic w_start;
  logic w_accept;
  logic w_pad;
  logic w_write;
  logic w_bit_last;
  logic w_col_last;
  logic w_row_end;
  logic w_img_end;

  assign w_start    = (r_state == StIdle) && i_start;
  assign w_accept   = (r_state == StAccept) && i_pix_valid;
  assign w_pad      = (r_state == StPad);
  assign w_write    = (r_state == StFlush) && i_out_full && i_mem_ready;
  assign w_bit_last = (r_bit_cnt == BitLast);

  out_pixel_counter #(
    .IMG_WIDTH  (IMG_WIDTH),
    .IMG_HEIGHT (IMG_HEIGHT)
  ) u_pix_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_clear    (w_start),
    .i_col_inc  (w_accept),
    .i_row_adv  (w_write && w_row_end),
    .o_col_last (w_col_last),
    .o_row_end  (w_row_end),
    .o_img_end  (w_img_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_bit_cnt <= '0;
      r_addr    <= BASE_ADDR;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_bit_cnt <= '0;
            r_addr    <= BASE_ADDR;
            r_state   <= StAccept;
          end
        end
        StAccept: begin
          if (i_pix_valid) begin
            r_bit_cnt <= r_bit_cnt + 5'd1;
            // A full word wins over row end when the row fills the word exactly.
            if (w_bit_last) begin
              r_state <= StFlush;
            end else if (w_col_last) begin
              r_state <= StPad;
            end
          end
        end
        StPad: begin
          r_bit_cnt <= r_bit_cnt + 5'd1;
          if (w_bit_last) begin
            r_state <= StFlush;
          end
        end
        StFlush: begin
          if (w_write) begin
            r_addr  <= r_addr + 32'(BYTES_PER_WORD);
            r_state <= w_img_end ? StDone : StAccept;
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign o_pix_ready        = (r_state == StAccept);
  assign o_out_en           = w_accept || w_pad;
  assign o_edge_pixel       = w_accept && i_pix_in;
  assign o_write_out_enable = w_write;
  assign o_write_addr       = r_addr;
  assign o_img_done         = (r_state == StDone);
  assign o_busy             = (r_state != StIdle);

endmodule

// File: tb/tb_output_write_ctrl.sv
// Scoreboard bench for output_write_ctrl: a 40x2 image at a wrapping base address,
// with a behavioural outputBuffer stand-in collecting the shifted bits.
module tb_output_write_ctrl;
  import sobel_out_pkg::*;

  localparam int unsigned W    = 40;
  localparam int unsigned H    = 2;
  localparam logic [31:0] BASE = 32'hFFFF_FFF8;

  typedef struct {
    logic [31:0] word;
    logic [31:0] addr;
    int          pads;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        pix_valid;
  logic        pix_in;
  logic        pix_ready;
  logic        out_en;
  logic        edge_pixel;
  logic        out_full;
  logic        mem_ready;
  logic        write_out_enable;
  logic [31:0] write_addr;
  logic        img_done;
  logic        busy;

  int n_pass  = 0;
  int n_total = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  output_write_ctrl #(
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .BASE_ADDR  (BASE)
  ) dut (
    .i_clk              (clk),
    .i_rst              (rst),
    .i_start            (start),
    .i_pix_valid        (pix_valid),
    .i_pix_in           (pix_in),
    .o_pix_ready        (pix_ready),
    .o_out_en           (out_en),
    .o_edge_pixel       (edge_pixel),
    .i_out_full         (out_full),
    .i_mem_ready        (mem_ready),
    .o_write_out_enable (write_out_enable),
    .o_write_addr       (write_addr),
    .o_img_done         (img_done),
    .o_busy             (busy)
  );

  // outputBuffer stand-in: first shifted bit ends up in the word MSB.
  logic [31:0] buf_word = '0;
  int          buf_cnt  = 0;
  always @(posedge clk) begin
    if (rst || write_out_enable) begin
      buf_word <= '0;
      buf_cnt  <= 0;
    end else if (out_en) begin
      buf_word <= {buf_word[30:0], edge_pixel};
      buf_cnt  <= buf_cnt + 1;
    end
  end
  assign out_full = (buf_cnt == 32);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard on every word write.
  int   pads    = 0;
  int   n_wr    = 0;
  int   n_done  = 0;
  logic prev_we = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      pads    = 0;
      prev_we = 1'b0;
    end else begin
      if (out_en && !pix_ready) pads++;
      if (write_out_enable) begin
        n_wr++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got addr %h word %h, expected no write",
                   write_addr, buf_word);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word", buf_word, e.word);
          chk("addr", write_addr, e.addr);
          chk("pad_cycles", pads, e.pads);
        end
        pads = 0;
      end
      if (img_done) begin
        n_done++;
        chk("done_after_last_write", prev_we, 1'b1);
        chk("done_words_left", exp_q.size(), 0);
      end
      prev_we = write_out_enable;
    end
  end

  task automatic push_row(input logic [39:0] p, input int row);
    exp_t e;
    e.word = p[39:8];
    e.addr = BASE + 32'(8 * row);
    e.pads = 0;
    exp_q.push_back(e);
    e.word = {p[7:0], 24'h0};
    e.addr = BASE + 32'(8 * row + 4);
    e.pads = 24;
    exp_q.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_pix(input logic b, input bit gap);
    int guard = 0;
    if (gap) begin
      pix_valid = 1'b0;
      @(posedge clk); #1;
    end
    pix_valid = 1'b1;
    pix_in    = b;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      guard++;
      if (guard > 200) break;
    end
    if (guard > 200) begin
      n_total++;
      $display("FAIL pix_ready_timeout: got no ready in 200 cycles, expected ready");
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic send_cols(input logic [39:0] p, input int c0, input int c1, input bit gaps);
    for (int c = c0; c <= c1; c++) begin
      send_pix(p[39-c], gaps && ($urandom_range(0, 1) == 1));
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 1'b0);
    chk({tag, "_out_en"}, out_en, 1'b0);
    chk({tag, "_edge_pixel"}, edge_pixel, 1'b0);
    chk({tag, "_write_en"}, write_out_enable, 1'b0);
    chk({tag, "_write_addr"}, write_addr, BASE);
    chk({tag, "_img_done"}, img_done, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic wait_done(input string tag, input int wr0);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (img_done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, seen, 1'b1);
    chk({tag, "_word_count"}, n_wr - wr0, H * words_per_row(W));
    @(negedge clk);
    chk({tag, "_busy_low"}, busy, 1'b0);
    chk({tag, "_done_single"}, img_done, 1'b0);
    @(posedge clk); #1;
  endtask

  initial begin
    int wr0;
    logic [39:0] p0;
    logic [39:0] p1;
    rst       = 1'b1;
    start     = 1'b0;
    pix_valid = 1'b0;
    pix_in    = 1'b0;
    mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk); #1;

    // Image A: no gaps, stray start while accepting.
    p0 = 40'hFF_FFFF_FFFF;
    p1 = 40'h12_3456_789A;
    push_row(p0, 0);
    push_row(p1, 1);
    wr0 = n_wr;
    pulse_start();
    send_cols(p0, 0, 4, 1'b0);
    @(negedge clk);
    chk("busy_in_accept", busy, 1'b1);
    @(posedge clk); #1;
    pulse_start();
    send_cols(p0, 5, 39, 1'b0);
    send_cols(p1, 0, 39, 1'b0);
    wait_done("imgA", wr0);

    // Image B: random valid gaps, memory stalled on the first flush.
    p0 = 40'hA5_5A0F_F0C3;
    p1 = 40'h00_0000_0081;
    push_row(p0, 0);
    push_row(p1, 1);
    wr0 = n_wr;
    mem_ready = 1'b0;
    pulse_start();
    send_cols(p0, 0, 31, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("stall_no_write", write_out_enable, 1'b0);
      chk("stall_pix_ready", pix_ready, 1'b0);
      chk("stall_addr", write_addr, BASE);
      @(posedge clk); #1;
    end
    mem_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_write", write_out_enable, 1'b1);
    @(posedge clk); #1;
    send_cols(p0, 32, 39, 1'b1);
    send_cols(p1, 0, 39, 1'b1);
    wait_done("imgB", wr0);

    // Image C: abandoned by reset after 17 pixels; nothing is written.
    pulse_start();
    send_cols(40'hFF_FFFF_FFFF, 0, 16, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset("midreset");
    @(posedge clk); #1;

    // Image D: restart must begin again at the base address.
    p0 = 40'h80_0000_0001;
    p1 = 40'hFF_FFFF_FFFE;
    push_row(p0, 0);
    push_row(p1, 1);
    wr0 = n_wr;
    pulse_start();
    send_cols(p0, 0, 39, 1'b0);
    send_cols(p1, 0, 39, 1'b0);
    wait_done("imgD", wr0);

    chk("img_done_total", n_done, 3);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
